// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the conv layer scheduler:
//   - sched_state_t : scheduler FSM state encoding
//   - NUM_LAYERS_DEF: default number of conv layers per run
//   - DRAIN_CYCLES  : engine pipeline depth after eng_valid
//   - LAYER_WBASE / LAYER_BBASE : per-layer weight/bias base addresses
//   - layer_wbase() / layer_bbase() : lookup helpers
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_NEXT  = 3'd5,
        ST_FIN   = 3'd6,
        ST_ERR   = 3'd7
    } sched_state_t;

    localparam int NUM_LAYERS_DEF = 4;
    localparam int DRAIN_CYCLES   = 4;

    // Each layer owns 9 weight words (3x3 kernel) and 3 bias words
    // (one per channel); element i belongs to layer i.
    localparam logic [3:0][6:0] LAYER_WBASE = {7'd27, 7'd18, 7'd9, 7'd0};
    localparam logic [3:0][4:0] LAYER_BBASE = {5'd9, 5'd6, 5'd3, 5'd0};

    function automatic logic [6:0] layer_wbase(input logic [1:0] idx);
        return LAYER_WBASE[idx];
    endfunction

    function automatic logic [4:0] layer_bbase(input logic [1:0] idx);
        return LAYER_BBASE[idx];
    endfunction

endpackage

// File: rtl/conv_wport_mux.sv
// ---------------------------------------------------------------------------
// conv_wport_mux
// Combinational arbiter for the shared SRAM bank write port.
// Ports:
//   i_host_gnt            host currently owns the port (wins over engine)
//   i_eng_own             scheduler is in a phase where the engine may write
//   i_host_wen/waddr/wdata host loader write request
//   i_eng_wen/waddr/wdata  conv engine write request
//   o_wen/o_waddr/o_wdata  muxed write port (wen active-low per bank)
// Requests from the side that does not own the port are simply dropped.
// ---------------------------------------------------------------------------
module conv_wport_mux #(
    parameter int DATA_BW = 270
) (
    input  logic               i_host_gnt,
    input  logic               i_eng_own,
    input  logic [3:0]         i_host_wen,
    input  logic [10:0]        i_host_waddr,
    input  logic [DATA_BW-1:0] i_host_wdata,
    input  logic [3:0]         i_eng_wen,
    input  logic [10:0]        i_eng_waddr,
    input  logic [DATA_BW-1:0] i_eng_wdata,
    output logic [3:0]         o_wen,
    output logic [10:0]        o_waddr,
    output logic [DATA_BW-1:0] o_wdata
);

    always_comb begin
        o_wen   = 4'hF;
        o_waddr = '0;
        o_wdata = '0;
        if (i_host_gnt) begin
            o_wen   = i_host_wen;
            o_waddr = i_host_waddr;
            o_wdata = i_host_wdata;
        end else if (i_eng_own) begin
            o_wen   = i_eng_wen;
            o_waddr = i_eng_waddr;
            o_wdata = i_eng_wdata;
        end
    end

endmodule

// File: rtl/conv_layer_sched.sv
// ---------------------------------------------------------------------------
// conv_layer_sched
// Sequences NUM_LAYERS conv layers through a single conv engine: host load,
// engine arm (reset + enable), run with watchdog, pipeline drain, next layer.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      begin a run (from IDLE or ERR)
//   host_load_done             host finished loading activations/weights
//   host_wen/waddr/wdata       host loader write request
//   host_gnt                   host owns the bank write port
//   eng_rst_n, eng_enable      conv engine reset (active-low) and start
//   eng_valid                  engine finished (level)
//   eng_wen/waddr/wdata        engine write request
//   sram_wen/waddr/wdata       muxed bank write port (combinational)
//   cfg_layer/wbase/bbase      current layer and its weight/bias bases
//   busy, done, err            status: active, run-complete pulse, sticky error
// All outputs except the sram_* mux are registered; they are decoded from
// the next state so they line up with the state register cycle for cycle.
// ---------------------------------------------------------------------------
module conv_layer_sched
    import conv_pkg::*;
#(
    parameter int          NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int          DATA_BW    = 270,
    parameter logic [15:0] WDOG_MAX   = 16'd4000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               host_load_done,
    input  logic [3:0]         host_wen,
    input  logic [10:0]        host_waddr,
    input  logic [DATA_BW-1:0] host_wdata,
    output logic               host_gnt,
    output logic               eng_rst_n,
    output logic               eng_enable,
    input  logic               eng_valid,
    input  logic [3:0]         eng_wen,
    input  logic [10:0]        eng_waddr,
    input  logic [DATA_BW-1:0] eng_wdata,
    output logic [3:0]         sram_wen,
    output logic [10:0]        sram_waddr,
    output logic [DATA_BW-1:0] sram_wdata,
    output logic [1:0]         cfg_layer,
    output logic [6:0]         cfg_wbase,
    output logic [4:0]         cfg_bbase,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [1:0]   r_phase;
    logic [1:0]   w_phase_nxt;
    logic [1:0]   r_layer;
    logic [1:0]   w_layer_nxt;
    logic [15:0]  r_wdog;
    logic         w_wdog_expire;
    logic         w_eng_own;

    logic         r_host_gnt;
    logic         r_eng_rst_n;
    logic         r_eng_enable;
    logic         r_busy;
    logic         r_done;
    logic         r_err;
    logic [6:0]   r_cfg_wbase;
    logic [4:0]   r_cfg_bbase;

    logic         w_host_gnt_nxt;
    logic         w_eng_rst_n_nxt;
    logic         w_eng_enable_nxt;
    logic         w_busy_nxt;
    logic         w_done_nxt;
    logic         w_err_nxt;

    // Expiry fires on the RUN cycle in which the count would reach WDOG_MAX,
    // so RUN lasts exactly WDOG_MAX cycles without eng_valid.
    assign w_wdog_expire = ({1'b0, r_wdog} + 17'd1) >= {1'b0, WDOG_MAX};

    // r_phase counts cycles spent in the current state; ARM and DRAIN use it
    // for their fixed lengths. eng_valid wins over watchdog expiry in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_layer_nxt = r_layer;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_layer_nxt = '0;
                end
            end
            ST_LOAD: begin
                if (host_load_done) w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (r_phase == 2'd1) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (eng_valid)          w_state_nxt = ST_DRAIN;
                else if (w_wdog_expire) w_state_nxt = ST_ERR;
            end
            ST_DRAIN: begin
                if (r_phase == DRAIN_LAST) w_state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (r_layer == LAST_LAYER) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_ARM;
                    w_layer_nxt = r_layer + 2'd1;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_layer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_phase_nxt = (w_state_nxt == r_state) ? r_phase + 2'd1 : 2'd0;

        // Engine is held in reset everywhere except the second ARM cycle,
        // RUN and DRAIN (engine keeps its results and the port while draining).
        w_eng_enable_nxt = ((w_state_nxt == ST_ARM) && (w_phase_nxt == 2'd1))
                           || (w_state_nxt == ST_RUN);
        w_eng_rst_n_nxt  = w_eng_enable_nxt || (w_state_nxt == ST_DRAIN);
        w_host_gnt_nxt   = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_ERR);
        w_busy_nxt       = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_ERR);
        w_done_nxt       = (w_state_nxt == ST_FIN);
        w_err_nxt        = (w_state_nxt == ST_ERR);
    end

    // State, counters, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_layer      <= '0;
            r_wdog       <= '0;
            r_host_gnt   <= 1'b0;
            r_eng_rst_n  <= 1'b0;
            r_eng_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cfg_wbase  <= '0;
            r_cfg_bbase  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_layer      <= w_layer_nxt;
            r_host_gnt   <= w_host_gnt_nxt;
            r_eng_rst_n  <= w_eng_rst_n_nxt;
            r_eng_enable <= w_eng_enable_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_cfg_wbase  <= layer_wbase(w_layer_nxt);
            r_cfg_bbase  <= layer_bbase(w_layer_nxt);
            if ((w_state_nxt == ST_ARM) && (r_state != ST_ARM)) begin
                r_wdog <= '0;
            end else if ((r_state == ST_RUN) && (r_wdog != 16'hFFFF)) begin
                r_wdog <= r_wdog + 16'd1;
            end
        end
    end

    assign w_eng_own = (r_state == ST_ARM) || (r_state == ST_RUN)
                       || (r_state == ST_DRAIN);

    conv_wport_mux #(
        .DATA_BW (DATA_BW)
    ) u_wport_mux (
        .i_host_gnt   (r_host_gnt),
        .i_eng_own    (w_eng_own),
        .i_host_wen   (host_wen),
        .i_host_waddr (host_waddr),
        .i_host_wdata (host_wdata),
        .i_eng_wen    (eng_wen),
        .i_eng_waddr  (eng_waddr),
        .i_eng_wdata  (eng_wdata),
        .o_wen        (sram_wen),
        .o_waddr      (sram_waddr),
        .o_wdata      (sram_wdata)
    );

    assign host_gnt   = r_host_gnt;
    assign eng_rst_n  = r_eng_rst_n;
    assign eng_enable = r_eng_enable;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cfg_layer  = r_layer;
    assign cfg_wbase  = r_cfg_wbase;
    assign cfg_bbase  = r_cfg_bbase;

endmodule

// File: tb/tb_conv_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_sched
// Bench for conv_layer_sched: reset values, directed write-port vectors in
// LOAD and RUN, watchdog error and recovery, full runs against a per-cycle
// phase-timeline model, valid/watchdog tie, and reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_conv_layer_sched;

    localparam int          DATA_BW  = 270;
    localparam logic [15:0] WDOG_MAX = 16'd4000;
    localparam int          WDOG     = 4000;

    // Bench-side names for where the scheduler should be on a given cycle.
    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_ARM1  = 2;
    localparam int PH_ARM2  = 3;
    localparam int PH_RUN   = 4;
    localparam int PH_DRAIN = 5;
    localparam int PH_NEXT  = 6;
    localparam int PH_FIN   = 7;
    localparam int PH_ERR   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               host_load_done;
    logic [3:0]         host_wen;
    logic [10:0]        host_waddr;
    logic [DATA_BW-1:0] host_wdata;
    logic               host_gnt;
    logic               eng_rst_n;
    logic               eng_enable;
    logic               eng_valid = 1'b0;
    logic [3:0]         eng_wen;
    logic [10:0]        eng_waddr;
    logic [DATA_BW-1:0] eng_wdata;
    logic [3:0]         sram_wen;
    logic [10:0]        sram_waddr;
    logic [DATA_BW-1:0] sram_wdata;
    logic [1:0]         cfg_layer;
    logic [6:0]         cfg_wbase;
    logic [4:0]         cfg_bbase;
    logic               busy;
    logic               done;
    logic               err;

    int checks = 0;
    int passed = 0;
    int engLat[4] = '{0, 0, 0, 0};
    int engCnt = 0;
    int enCycles = 0;

    always #5 clk = ~clk;

    conv_layer_sched #(
        .NUM_LAYERS (4),
        .DATA_BW    (DATA_BW),
        .WDOG_MAX   (WDOG_MAX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .host_load_done (host_load_done),
        .host_wen       (host_wen),
        .host_waddr     (host_waddr),
        .host_wdata     (host_wdata),
        .host_gnt       (host_gnt),
        .eng_rst_n      (eng_rst_n),
        .eng_enable     (eng_enable),
        .eng_valid      (eng_valid),
        .eng_wen        (eng_wen),
        .eng_waddr      (eng_waddr),
        .eng_wdata      (eng_wdata),
        .sram_wen       (sram_wen),
        .sram_waddr     (sram_waddr),
        .sram_wdata     (sram_wdata),
        .cfg_layer      (cfg_layer),
        .cfg_wbase      (cfg_wbase),
        .cfg_bbase      (cfg_bbase),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Engine model: counts enabled cycles since its last reset and raises
    // eng_valid (held) once the latency for the configured layer is reached.
    // A latency of 0 means the engine never finishes.
    always @(negedge clk) begin
        if (eng_rst_n !== 1'b1) begin
            engCnt    = 0;
            eng_valid = 1'b0;
        end else if (eng_enable === 1'b1) begin
            engCnt = engCnt + 1;
            if ((engLat[cfg_layer] != 0) && (engCnt >= engLat[cfg_layer]))
                eng_valid = 1'b1;
        end
    end

    // Number of clock cycles during which eng_enable was high.
    always @(posedge clk) begin
        if (eng_enable === 1'b1) enCycles <= enCycles + 1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not complete, got hang required finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic checkWide(input string name, input logic [DATA_BW-1:0] act,
                             input logic [DATA_BW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DATA_BW-1:0] randData();
        logic [287:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        return t[DATA_BW-1:0];
    endfunction

    // Random write requests on both sides of the port.
    task automatic applyStimulus();
        host_wen   = 4'($urandom);
        host_waddr = 11'($urandom);
        host_wdata = randData();
        eng_wen    = 4'($urandom);
        eng_waddr  = 11'($urandom);
        eng_wdata  = randData();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".busy"},      64'(busy),       64'(0));
        checkOutput({tag, ".host_gnt"},  64'(host_gnt),   64'(0));
        checkOutput({tag, ".eng_en"},    64'(eng_enable), 64'(0));
        checkOutput({tag, ".eng_rst_n"}, 64'(eng_rst_n),  64'(0));
        checkOutput({tag, ".done"},      64'(done),       64'(0));
        checkOutput({tag, ".err"},       64'(err),        64'(0));
        checkOutput({tag, ".layer"},     64'(cfg_layer),  64'(0));
        checkOutput({tag, ".wbase"},     64'(cfg_wbase),  64'(0));
        checkOutput({tag, ".bbase"},     64'(cfg_bbase),  64'(0));
        checkOutput({tag, ".sram_wen"},  64'(sram_wen),   64'(4'hF));
    endtask

    // Registered outputs expected for a cycle in phase ph of layer ly.
    task automatic checkPhase(input int ph, input int ly, input string tag);
        logic [18:0] expv;
        logic [18:0] actv;
        expv = {(ph != PH_IDLE) && (ph != PH_ERR),
                (ph == PH_LOAD) || (ph == PH_ERR),
                (ph == PH_ARM2) || (ph == PH_RUN),
                ph == PH_FIN,
                ph == PH_ERR,
                2'(ly), 7'(ly * 9), 5'(ly * 3)};
        actv = {busy, host_gnt, eng_enable, done, err, cfg_layer, cfg_wbase, cfg_bbase};
        checkOutput({tag, ".status"}, 64'(actv), 64'(expv));
        if ((ph == PH_ARM1) || (ph == PH_IDLE) || (ph == PH_ERR))
            checkOutput({tag, ".eng_rst_n"}, 64'(eng_rst_n), 64'(0));
        if ((ph == PH_ARM2) || (ph == PH_RUN))
            checkOutput({tag, ".eng_rst_n"}, 64'(eng_rst_n), 64'(1));
    endtask

    // Write-port ownership: host in LOAD/ERR, engine in ARM..DRAIN, else closed.
    task automatic checkPort(input int ph, input string tag);
        if ((ph == PH_LOAD) || (ph == PH_ERR)) begin
            checkOutput({tag, ".wen"},  64'(sram_wen),   64'(host_wen));
            checkOutput({tag, ".addr"}, 64'(sram_waddr), 64'(host_waddr));
            checkWide({tag, ".data"}, sram_wdata, host_wdata);
        end else if ((ph >= PH_ARM1) && (ph <= PH_DRAIN)) begin
            checkOutput({tag, ".wen"},  64'(sram_wen),   64'(eng_wen));
            checkOutput({tag, ".addr"}, 64'(sram_waddr), 64'(eng_waddr));
            checkWide({tag, ".data"}, sram_wdata, eng_wdata);
        end else begin
            checkOutput({tag, ".wen"}, 64'(sram_wen), 64'(4'hF));
        end
    endtask

    // Builds the expected phase timeline of a complete 4-layer run from the
    // load delay and per-layer engine latencies, then starts the run and
    // compares every cycle against it. Engine latency L gives L-1 RUN cycles.
    task automatic runModel(input int loadDelay, input int l0, input int l1,
                            input int l2, input int l3);
        int lats[4];
        int ph[$];
        int ly[$];
        int doneSeen;
        lats[0] = l0; lats[1] = l1; lats[2] = l2; lats[3] = l3;
        for (int i = 0; i < 4; i++) engLat[i] = lats[i];
        for (int i = 0; i < loadDelay; i++) begin ph.push_back(PH_LOAD); ly.push_back(0); end
        for (int l = 0; l < 4; l++) begin
            ph.push_back(PH_ARM1); ly.push_back(l);
            ph.push_back(PH_ARM2); ly.push_back(l);
            for (int i = 0; i < lats[l] - 1; i++) begin ph.push_back(PH_RUN); ly.push_back(l); end
            for (int i = 0; i < 4; i++) begin ph.push_back(PH_DRAIN); ly.push_back(l); end
            ph.push_back(PH_NEXT); ly.push_back(l);
        end
        ph.push_back(PH_FIN);  ly.push_back(3);
        ph.push_back(PH_IDLE); ly.push_back(3);

        start = 1'b1;
        host_load_done = 1'b0;
        applyStimulus();
        @(negedge clk);
        start = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < ph.size(); i++) begin
            checkPhase(ph[i], ly[i], $sformatf("run[%0d]", i));
            if (done === 1'b1) doneSeen++;
            host_load_done = (i == loadDelay - 1);
            applyStimulus();
            #1;
            checkPort(ph[i], $sformatf("run[%0d]", i));
            @(negedge clk);
        end
        host_load_done = 1'b0;
        checkOutput("run.doneCount", 64'(doneSeen), 64'(1));
    endtask

    typedef struct {
        bit          inRun;
        bit          pulseStart;
        logic [3:0]  hostWen;
        logic [10:0] hostAddr;
        logic [3:0]  engWen;
        logic [10:0] engAddr;
        logic [3:0]  expWen;
        logic [10:0] expAddr;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   snap;
        bit   seen;

        vecs[0] = '{0, 0, 4'b1110, 11'h123, 4'b0000, 11'h7FF, 4'b1110, 11'h123};
        vecs[1] = '{0, 0, 4'b1111, 11'h001, 4'b0101, 11'h002, 4'b1111, 11'h001};
        vecs[2] = '{0, 1, 4'b0111, 11'h400, 4'b1011, 11'h055, 4'b0111, 11'h400};
        vecs[3] = '{1, 0, 4'b1110, 11'h123, 4'b1111, 11'h0AA, 4'b1111, 11'h0AA};
        vecs[4] = '{1, 0, 4'b1110, 11'h3C3, 4'b0011, 11'h10F, 4'b0011, 11'h10F};
        vecs[5] = '{1, 1, 4'b0000, 11'h5A5, 4'b1100, 11'h00F, 4'b1100, 11'h00F};

        rst_n          = 1'b0;
        start          = 1'b0;
        host_load_done = 1'b0;
        applyStimulus();
        host_wen = 4'b1110;
        eng_wen  = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        checkReset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] host_load_done while idle");
        host_load_done = 1'b1;
        @(negedge clk);
        host_load_done = 1'b0;
        @(negedge clk);
        checkOutput("idleLoadDone.busy",     64'(busy),     64'(0));
        checkOutput("idleLoadDone.host_gnt", 64'(host_gnt), 64'(0));

        $display("[TB] directed write-port vectors, engine never finishes");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].inRun && !vecs[v-1].inRun) begin
                snap = enCycles;
                host_load_done = 1'b1;
                @(negedge clk);
                host_load_done = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    if (eng_enable === 1'b1) seen = 1'b1;
                    else @(negedge clk);
                end
                checkOutput("arm.enableSeen", 64'(seen), 64'(1));
                @(negedge clk);
            end
            host_wen   = vecs[v].hostWen;
            host_waddr = vecs[v].hostAddr;
            host_wdata = randData();
            eng_wen    = vecs[v].engWen;
            eng_waddr  = vecs[v].engAddr;
            eng_wdata  = randData();
            start      = vecs[v].pulseStart;
            #1;
            checkOutput($sformatf("vec[%0d].wen", v),  64'(sram_wen),   64'(vecs[v].expWen));
            checkOutput($sformatf("vec[%0d].addr", v), 64'(sram_waddr), 64'(vecs[v].expAddr));
            checkWide($sformatf("vec[%0d].data", v), sram_wdata,
                      vecs[v].inRun ? eng_wdata : host_wdata);
            @(negedge clk);
            start = 1'b0;
            checkOutput($sformatf("vec[%0d].busy", v),   64'(busy),       64'(1));
            checkOutput($sformatf("vec[%0d].gnt", v),    64'(host_gnt),   64'(!vecs[v].inRun));
            checkOutput($sformatf("vec[%0d].enable", v), 64'(eng_enable), 64'(vecs[v].inRun));
            checkOutput($sformatf("vec[%0d].layer", v),  64'(cfg_layer),  64'(0));
        end

        $display("[TB] waiting for watchdog expiry");
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (err === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("wdog.errSeen",    64'(seen),              64'(1));
        checkOutput("wdog.enCycles",   64'(enCycles - snap),   64'(WDOG + 1));
        checkOutput("wdog.eng_rst_n",  64'(eng_rst_n),         64'(0));
        checkOutput("wdog.host_gnt",   64'(host_gnt),          64'(1));
        checkOutput("wdog.busy",       64'(busy),              64'(0));
        applyStimulus();
        #1;
        checkPort(PH_ERR, "wdog");
        repeat (3) @(negedge clk);
        checkOutput("wdog.errSticky",  64'(err),               64'(1));

        $display("[TB] restart from error, full run with 1300-cycle engine");
        runModel(10, 1300, 1300, 1300, 1300);

        $display("[TB] randomized runs");
        for (int r = 0; r < 3; r++)
            runModel(int'($urandom_range(1, 12)), int'($urandom_range(2, 50)),
                     int'($urandom_range(2, 50)), int'($urandom_range(2, 50)),
                     int'($urandom_range(2, 50)));

        $display("[TB] eng_valid on the watchdog limit cycle");
        runModel(3, WDOG + 1, 10, int'($urandom_range(2, 20)), 10);

        $display("[TB] reset during layer 2 run");
        for (int i = 0; i < 4; i++) engLat[i] = 30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        host_load_done = 1'b1;
        @(negedge clk);
        host_load_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            if ((cfg_layer == 2'd2) && (eng_enable === 1'b1)) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput("midReset.layer2Seen", 64'(seen), 64'(1));
        repeat (5) @(negedge clk);
        checkOutput("midReset.inRun", 64'(eng_enable), 64'(1));
        rst_n    = 1'b0;
        host_wen = 4'b1110;
        @(negedge clk);
        #1;
        checkReset("midReset");
        rst_n = 1'b1;
        @(negedge clk);
        runModel(5, 20, 20, 20, 20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
